// File: rtl/transmissor_16.sv
// transmissor_16: serial transmitter for 16-bit words.
// On partida the word on dados is latched and sent as two asynchronous frames,
// low byte first. Each frame is: start(0), 8 data bits LSB first, even parity,
// stop(1). All outputs are registered.
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous, active-high
//   partida      - start request, sampled only in REPOUSO
//   dados[15:0]  - word to send, latched when leaving REPOUSO
//   saida_serial - serial line, idle high
//   ocupado      - high in every state except REPOUSO
//   pronto       - one-cycle pulse in FIM
//   db_estado    - current FSM state code
module transmissor_16 #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [15:0] dados,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [2:0]  db_estado
);

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned FRAME_W   = 11;
  localparam int unsigned BIT_CNT_W = 4;
  // CLKS_PER_BIT = 1 still needs a 1-bit baud counter
  localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    REPOUSO     = 3'd0,
    CARREGA_1   = 3'd1,
    TRANSMITE_1 = 3'd2,
    CARREGA_2   = 3'd3,
    TRANSMITE_2 = 3'd4,
    FIM         = 3'd5
  } state_t;

  state_t                 r_state;
  logic [WORD_W-1:0]      r_word;
  logic [FRAME_W-1:0]     r_frame;
  logic [BAUD_W-1:0]      r_baud;
  logic [BIT_CNT_W-1:0]   r_bit;
  logic                   r_saida;
  logic                   r_ocupado;
  logic                   r_pronto;

  state_t                 w_next_state;
  logic [WORD_W-1:0]      w_next_word;
  logic [FRAME_W-1:0]     w_next_frame;
  logic [BAUD_W-1:0]      w_next_baud;
  logic [BIT_CNT_W-1:0]   w_next_bit;
  logic                   w_next_saida;
  logic                   w_baud_done;

  // Frame layout, bit 0 leaves first: {stop, parity, data[7:0], start}
  function automatic logic [FRAME_W-1:0] f_frame(input logic [BYTE_W-1:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  assign w_baud_done = (r_baud == BAUD_LAST);

  // Next-state, datapath and next-output logic
  always_comb begin
    w_next_state = r_state;
    w_next_word  = r_word;
    w_next_frame = r_frame;
    w_next_baud  = r_baud;
    w_next_bit   = r_bit;
    w_next_saida = 1'b1;

    case (r_state)
      REPOUSO: begin
        if (partida) begin
          w_next_state = CARREGA_1;
          w_next_word  = dados;
        end
      end
      CARREGA_1: begin
        w_next_frame = f_frame(r_word[BYTE_W-1:0]);
        w_next_baud  = '0;
        w_next_bit   = '0;
        w_next_state = TRANSMITE_1;
      end
      CARREGA_2: begin
        w_next_frame = f_frame(r_word[WORD_W-1:BYTE_W]);
        w_next_baud  = '0;
        w_next_bit   = '0;
        w_next_state = TRANSMITE_2;
      end
      TRANSMITE_1, TRANSMITE_2: begin
        if (w_baud_done) begin
          w_next_baud  = '0;
          w_next_frame = {1'b1, r_frame[FRAME_W-1:1]};
          if (r_bit == BIT_LAST) begin
            w_next_bit   = '0;
            w_next_state = (r_state == TRANSMITE_1) ? CARREGA_2 : FIM;
          end else begin
            w_next_bit = r_bit + BIT_CNT_W'(1);
          end
        end else begin
          w_next_baud = r_baud + BAUD_W'(1);
        end
      end
      FIM: begin
        w_next_state = REPOUSO;
      end
      default: begin
        w_next_state = REPOUSO;
      end
    endcase

    // Line follows the frame only while a frame is on the wire
    if ((w_next_state == TRANSMITE_1) || (w_next_state == TRANSMITE_2)) begin
      w_next_saida = w_next_frame[0];
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= REPOUSO;
      r_word    <= '0;
      r_frame   <= '1;
      r_baud    <= '0;
      r_bit     <= '0;
      r_saida   <= 1'b1;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_word    <= w_next_word;
      r_frame   <= w_next_frame;
      r_baud    <= w_next_baud;
      r_bit     <= w_next_bit;
      r_saida   <= w_next_saida;
      r_ocupado <= (w_next_state != REPOUSO);
      r_pronto  <= (w_next_state == FIM);
    end
  end

  assign saida_serial = r_saida;
  assign ocupado      = r_ocupado;
  assign pronto       = r_pronto;
  assign db_estado    = r_state;

endmodule

// File: tb/tb_transmissor_16.sv
// Testbench for transmissor_16: a scoreboard of per-cycle expected
// (state, line) samples is filled when a transfer is started and drained as
// the DUT runs; a receiver model decodes the frames back into a word.
module tb_transmissor_16;

  localparam int CPB_A = 4;
  localparam int CPB_B = 1;

  logic        clock;
  logic        reset;
  logic        partida_a, partida_b;
  logic [15:0] dados_a, dados_b;
  logic        saida_a, ocupado_a, pronto_a;
  logic        saida_b, ocupado_b, pronto_b;
  logic [2:0]  estado_a, estado_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] state;
    logic       line;
  } sample_t;

  sample_t     exp_q[$];
  logic [15:0] word_q[$];

  transmissor_16 #(.CLKS_PER_BIT(CPB_A)) u_dut_a (
    .clock(clock), .reset(reset), .partida(partida_a), .dados(dados_a),
    .saida_serial(saida_a), .ocupado(ocupado_a), .pronto(pronto_a), .db_estado(estado_a)
  );

  transmissor_16 #(.CLKS_PER_BIT(CPB_B)) u_dut_b (
    .clock(clock), .reset(reset), .partida(partida_b), .dados(dados_b),
    .saida_serial(saida_b), .ocupado(ocupado_b), .pronto(pronto_b), .db_estado(estado_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bit idx of a frame carrying byte b: start, data LSB first, even parity, stop
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9) return 1'((ones % 2) != 0);
    return 1'b1;
  endfunction

  // Expected sample j cycles after the sampling edge of partida
  function automatic sample_t exp_sample(input logic [15:0] w, input int c, input int j);
    sample_t s;
    s.line = 1'b1;
    if (j == 0) begin
      s.state = 3'd1;
    end else if (j <= 11*c) begin
      s.state = 3'd2;
      s.line  = frame_bit(w[7:0], (j-1)/c);
    end else if (j == 11*c+1) begin
      s.state = 3'd3;
    end else if (j <= 22*c+1) begin
      s.state = 3'd4;
      s.line  = frame_bit(w[15:8], (j-11*c-2)/c);
    end else if (j == 22*c+2) begin
      s.state = 3'd5;
    end else begin
      s.state = 3'd0;
    end
    return s;
  endfunction

  task automatic push_word(input logic [15:0] w, input int c);
    for (int j = 0; j <= 22*c+2; j++) exp_q.push_back(exp_sample(w, c, j));
    word_q.push_back(w);
  endtask

  task automatic push_idle();
    sample_t s;
    s.state = 3'd0;
    s.line  = 1'b1;
    exp_q.push_back(s);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    partida_a = 1'b0;
    partida_b = 1'b0;
    dados_a   = 16'h0000;
    dados_b   = 16'h0000;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (saida_a !== 1'b1)   begin errors++; $display("FAIL reset saida got %b want 1", saida_a); end
    checks++; if (ocupado_a !== 1'b0) begin errors++; $display("FAIL reset ocupado got %b want 0", ocupado_a); end
    checks++; if (pronto_a !== 1'b0)  begin errors++; $display("FAIL reset pronto got %b want 0", pronto_a); end
    checks++; if (estado_a !== 3'd0)  begin errors++; $display("FAIL reset estado got %0d want 0", estado_a); end
    checks++; if (estado_b !== 3'd0 || saida_b !== 1'b1) begin
      errors++; $display("FAIL reset_b estado=%0d saida=%b want 0/1", estado_b, saida_b);
    end
    // dados toggling without partida must do nothing
    for (int i = 0; i < 6; i++) begin
      dados_a = 16'($urandom);
      @(posedge clock);
      #1;
      checks++;
      if (estado_a !== 3'd0 || saida_a !== 1'b1 || ocupado_a !== 1'b0) begin
        errors++;
        $display("FAIL idle_toggle i=%0d estado=%0d saida=%b ocupado=%b want 0/1/0", i, estado_a, saida_a, ocupado_a);
      end
    end
  endtask

  // One transfer on DUT A. inj_j >= 0: pulse partida and drive 16'hFFFF at
  // that cycle. rst_j >= 0: assert reset after that cycle and abandon.
  task automatic test_transmission(input string name, input logic [15:0] w,
                                   input int inj_j, input int rst_j);
    sample_t     e;
    logic [10:0] rx_lo, rx_hi;
    logic [15:0] rx_word, want_word;
    int          n_pronto, n_busy;
    bit          aborted;
    n_pronto = 0;
    n_busy   = 0;
    aborted  = 1'b0;
    rx_lo    = '0;
    rx_hi    = '0;

    dados_a   = w;
    partida_a = 1'b1;
    push_word(w, CPB_A);
    push_idle();

    for (int j = 0; j <= 22*CPB_A+3; j++) begin
      @(posedge clock);
      #1;
      if (j == 0) begin
        partida_a = 1'b0;
        dados_a   = ~w;
      end
      if (inj_j >= 0 && j == inj_j + 1) partida_a = 1'b0;
      if (pronto_a === 1'b1)  n_pronto++;
      if (ocupado_a === 1'b1) n_busy++;
      if (j >= 1 && j <= 11*CPB_A && ((j-1) % CPB_A) == CPB_A/2)
        rx_lo[(j-1)/CPB_A] = saida_a;
      if (j >= 11*CPB_A+2 && j <= 22*CPB_A+1 && ((j-11*CPB_A-2) % CPB_A) == CPB_A/2)
        rx_hi[(j-11*CPB_A-2)/CPB_A] = saida_a;

      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s j=%0d scoreboard empty", name, j);
      end else begin
        e = exp_q.pop_front();
        checks++; if (estado_a !== e.state) begin errors++; $display("FAIL %s j=%0d estado got %0d want %0d", name, j, estado_a, e.state); end
        checks++; if (saida_a !== e.line)   begin errors++; $display("FAIL %s j=%0d saida got %b want %b", name, j, saida_a, e.line); end
        checks++; if (ocupado_a !== (e.state != 3'd0)) begin errors++; $display("FAIL %s j=%0d ocupado got %b want %b", name, j, ocupado_a, e.state != 3'd0); end
        checks++; if (pronto_a !== (e.state == 3'd5))  begin errors++; $display("FAIL %s j=%0d pronto got %b want %b", name, j, pronto_a, e.state == 3'd5); end
      end

      if (inj_j >= 0 && j == inj_j) begin
        partida_a = 1'b1;
        dados_a   = 16'hFFFF;
      end

      if (rst_j >= 0 && j == rst_j) begin
        reset = 1'b1;
        #1;
        checks++;
        if (estado_a !== 3'd0 || saida_a !== 1'b1 || ocupado_a !== 1'b0 || pronto_a !== 1'b0) begin
          errors++;
          $display("FAIL %s async_reset estado=%0d saida=%b ocupado=%b pronto=%b want 0/1/0/0",
                   name, estado_a, saida_a, ocupado_a, pronto_a);
        end
        exp_q.delete();
        word_q.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clock);
          #1;
          checks++;
          if (pronto_a !== 1'b0 || estado_a !== 3'd0) begin
            errors++;
            $display("FAIL %s post_reset k=%0d pronto=%b estado=%0d want 0/0", name, k, pronto_a, estado_a);
          end
        end
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted) begin
      checks++; if (n_pronto != 1) begin errors++; $display("FAIL %s pronto_count got %0d want 1", name, n_pronto); end
      checks++; if (n_busy != 22*CPB_A+3) begin errors++; $display("FAIL %s ocupado_cycles got %0d want %0d", name, n_busy, 22*CPB_A+3); end
      checks++;
      if (rx_lo[0] !== 1'b0 || rx_lo[10] !== 1'b1 || rx_hi[0] !== 1'b0 || rx_hi[10] !== 1'b1) begin
        errors++; $display("FAIL %s framing lo=%b hi=%b", name, rx_lo, rx_hi);
      end
      checks++;
      if ((^rx_lo[9:1]) !== 1'b0 || (^rx_hi[9:1]) !== 1'b0) begin
        errors++; $display("FAIL %s parity lo=%b hi=%b", name, rx_lo, rx_hi);
      end
      rx_word   = {rx_hi[8:1], rx_lo[8:1]};
      want_word = (word_q.size() != 0) ? word_q.pop_front() : 16'hxxxx;
      checks++;
      if (rx_word !== want_word) begin
        errors++; $display("FAIL %s rx_word got %h want %h", name, rx_word, want_word);
      end
    end
  endtask

  // Two words on DUT B with partida held high, one cycle per bit
  task automatic test_back_to_back(input logic [15:0] w1, input logic [15:0] w2);
    sample_t e;
    int      n_pronto;
    n_pronto  = 0;
    dados_b   = w1;
    partida_b = 1'b1;
    push_word(w1, CPB_B);
    push_idle();
    push_word(w2, CPB_B);
    push_idle();
    word_q.delete();

    for (int j = 0; j <= 51; j++) begin
      @(posedge clock);
      #1;
      if (j == 1)  dados_b   = w2;
      if (j == 26) partida_b = 1'b0;
      if (pronto_b === 1'b1) n_pronto++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b2b j=%0d scoreboard empty", j);
      end else begin
        e = exp_q.pop_front();
        checks++; if (estado_b !== e.state) begin errors++; $display("FAIL b2b j=%0d estado got %0d want %0d", j, estado_b, e.state); end
        checks++; if (saida_b !== e.line)   begin errors++; $display("FAIL b2b j=%0d saida got %b want %b", j, saida_b, e.line); end
        checks++; if (ocupado_b !== (e.state != 3'd0)) begin errors++; $display("FAIL b2b j=%0d ocupado got %b want %b", j, ocupado_b, e.state != 3'd0); end
        checks++; if (pronto_b !== (e.state == 3'd5))  begin errors++; $display("FAIL b2b j=%0d pronto got %b want %b", j, pronto_b, e.state == 3'd5); end
      end
    end
    checks++;
    if (n_pronto != 2) begin errors++; $display("FAIL b2b pronto_count got %0d want 2", n_pronto); end
  endtask

  initial begin
    test_reset();
    test_transmission("basic",       16'hA55A, -1, -1);
    test_transmission("odd_parity",  16'h0107, -1, -1);
    test_transmission("ignored",     16'h1234, 10, -1);
    test_transmission("reset_mid",   16'hC3E1, -1, 67);
    test_transmission("after_reset", 16'h96F0, -1, -1);
    test_back_to_back(16'hBEEF, 16'h0F0F);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
